cal_seq: RTL and testbench
==========================

Name: cal_seq

Overview:
- Parametrised successor to the single-mode sum calculator.
- Computes one of four series over a run-time term count `n`, pacing one term every `N_COMPUTE` clocks.
- Reports busy, done and sticky overflow, and drives the result as hex on a multiplexed active-low 7-segment display.
- Sits between the board switch decode and the SEG/AN pins.

Parameters:
- BITWIDTH, 8, width of the result and of `n_terms`.
- N_COMPUTE, 2, clocks per accumulated term; must be ≥1.
- N_DISPLAY, 2, clocks each digit stays enabled; must be ≥1.
- N_DIGITS, 2, number of hex digits scanned; `N_DIGITS*4` must be ≥ BITWIDTH.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level input; rising edge launches a run.
- clear  in  1  synchronous soft clear.
- mode  in  2  series select: 00 sum k, 01 sum k², 10 product k (n!), 11 sum (2k−1).
- n_terms  in  BITWIDTH  number of terms.
- result  out  BITWIDTH  running/final value.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- overflow  out  1  sticky; some step exceeded 2^BITWIDTH−1.
- seg  out  8  active-low {dp,g,f,e,d,c,b,a}.
- an  out  N_DIGITS  active-low digit enables.

Behaviour:
- Reset (rst_n=0, async):
  - state IDLE; result, busy, done, overflow = 0.
  - Start-edge register = 0; scan counter and digit index = 0.
  - an = all ones except bit0 = 0; seg shows digit 0 of result (0 → 0xC0).
- Start edge: `start` is high and the registered previous `start` is low. It is acted on only in IDLE or DONE and ignored in RUN. Holding `start` high never retriggers.
- On the start edge (edge E0):
  - mode and n_terms are latched.
  - result ← 1 for mode 10, else 0; overflow ← 0; k ← 1; tick ← 0.
  - n_terms = 0 → state DONE at E0 (done high after E0, result = identity value).
  - n_terms ≥ 1 → state RUN.
- RUN:
  - tick counts 0..N_COMPUTE−1 and wraps.
  - At tick = N_COMPUTE−1, result ← result op term(k) modulo 2^BITWIDTH, then k ← k+1.
  - Terms: k, k², k, 2k−1. Ops: +, +, ×, +.
  - Intermediates are computed at 2·BITWIDTH width. Any nonzero bit above BITWIDTH−1 (term or sum/product) sets overflow; overflow stays set until the next start, clear or reset.
  - Term n is applied at edge E0 + n·N_COMPUTE, and state ← DONE on that same edge.
  - busy = 1 exactly for clocks E0+1 .. E0+n·N_COMPUTE.
- DONE: result, overflow and done are held until a start edge (new run) or clear.
- clear = 1 (synchronous):
  - Any state → IDLE; result, overflow, busy, done ← 0.
  - Takes priority over a simultaneous start edge.
  - Display scanning continues.
- States: IDLE, RUN, DONE, encoded in 2 bits; any illegal encoding → IDLE.
- Display scanner:
  - Runs free in every state, independent of the FSM.
  - Scan counter 0..N_DISPLAY−1; on wrap, digit index d advances 0→1→…→N_DIGITS−1→0.
  - an has only bit d low.
  - seg[6:0] = hex glyph of result[4d+3:4d], with bits beyond BITWIDTH read as 0.
  - seg[7] (dp) = ~overflow when d = 0, else 1.
  - Outputs are registered; glyph and enable change on the same edge.
- Glyphs, seg[7:0] with dp off:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E

Decomposition:
- Package cal_seq_pkg:
  - Mode constants MODE_SUM, MODE_SQR, MODE_FACT, MODE_ODD.
  - State encodings ST_IDLE, ST_RUN, ST_DONE.
  - Function hex_to_seg(4-bit) → 7-bit active-low glyph.
- One sub-module seg_scan (params N_DIGITS, N_DISPLAY, WIDTH):
  - Inputs: clk, rst_n, value, dp_n.
  - Outputs: seg, an.
- FSM and datapath stay in cal_seq.

Test Plan (BITWIDTH=8, N_COMPUTE=2, N_DISPLAY=2, N_DIGITS=2):
1. mode 00, n=10, start edge at E0 → busy high E0+1..E0+20; done high after E0+20; result 0x37; overflow 0. Start held high afterwards → no new run.
2. mode 01, n=7 → result 0x8C, overflow 0. Then mode 01, n=9 → result 0x1D, overflow 1, dp low on digit 0.
3. mode 10, n=5 → 0x78, overflow 0. Then n=6 → 0xD0, overflow 1. A new start clears overflow at E0.
4. mode 10, n=0 → done after E0, result 0x01, busy never high. mode 11, n=0 → result 0x00. mode 11, n=4 → 0x10.
5. mode 00, n=20: rst_n low during RUN → all outputs 0 immediately, an=2'b10. clear=1 with a simultaneous start edge → IDLE, result 0. A later start edge runs to result 0xD2.
6. result 0x37 → an 2'b10 with seg 0xF8 for 2 clocks, then an 2'b01 with seg 0xB0 for 2 clocks, repeating.

Source files
------------

// File: rtl/cal_seq_pkg.sv
// Shared constants and helpers for the series calculator: mode codes,
// FSM state encoding and the hex-to-7-segment glyph table.
package cal_seq_pkg;

    localparam logic [1:0] MODE_SUM  = 2'b00;
    localparam logic [1:0] MODE_SQR  = 2'b01;
    localparam logic [1:0] MODE_FACT = 2'b10;
    localparam logic [1:0] MODE_ODD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; dp is added by the caller.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Free-running multiplexed hex display driver. One digit is enabled at a
// time; the glyph and the enable are registered together so they switch on the same edge.
module seg_scan #(
    parameter int N_DIGITS  = 2,
    parameter int N_DISPLAY = 2,
    parameter int WIDTH     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    value,
    input  logic                dp_n,
    output logic [7:0]          seg,
    output logic [N_DIGITS-1:0] an
);
    import cal_seq_pkg::*;

    localparam int CW = (N_DISPLAY > 1) ? $clog2(N_DISPLAY) : 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CW-1:0]              cnt_reg, cnt_next;
    logic [DW-1:0]              dig_reg, dig_next;
    logic [7:0]                 seg_reg, seg_next;
    logic [N_DIGITS-1:0]        an_reg, an_next;
    logic [N_DIGITS-1:0][3:0]   nib_vec;

    // Nibbles that extend past the value width read as zero.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
        for (genvar gb = 0; gb < 4; gb++) begin : g_bit
            if (4 * gi + gb < WIDTH) begin : g_in
                assign nib_vec[gi][gb] = value[4 * gi + gb];
            end else begin : g_pad
                assign nib_vec[gi][gb] = 1'b0;
            end
        end
        assign an_next[gi] = ~(dig_next == DW'(gi));
    end

    always_comb begin
        cnt_next = cnt_reg + CW'(1);
        dig_next = dig_reg;
        if (cnt_reg == CW'(N_DISPLAY - 1)) begin
            cnt_next = '0;
            dig_next = (dig_reg == DW'(N_DIGITS - 1)) ? '0 : dig_reg + DW'(1);
        end
        seg_next = {(dig_next == '0) ? dp_n : 1'b1, hex_to_seg(nib_vec[dig_next])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            dig_reg <= '0;
            an_reg  <= ~N_DIGITS'(1);
            seg_reg <= {1'b1, hex_to_seg(4'h0)};
        end else begin
            cnt_reg <= cnt_next;
            dig_reg <= dig_next;
            an_reg  <= an_next;
            seg_reg <= seg_next;
        end
    end

    assign seg = seg_reg;
    assign an  = an_reg;

endmodule

// File: rtl/cal_seq.sv
// Run-time selectable series calculator (sum k, sum k^2, n!, sum 2k-1) that
// accumulates one term every N_COMPUTE clocks and shows the result on a scanned hex display.
module cal_seq #(
    parameter int BITWIDTH  = 8,
    parameter int N_COMPUTE = 2,
    parameter int N_DISPLAY = 2,
    parameter int N_DIGITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clear,
    input  logic [1:0]          mode,
    input  logic [BITWIDTH-1:0] n_terms,
    output logic [BITWIDTH-1:0] result,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [7:0]          seg,
    output logic [N_DIGITS-1:0] an
);
    import cal_seq_pkg::*;

    localparam int TW = (N_COMPUTE > 1) ? $clog2(N_COMPUTE) : 1;
    localparam int W2 = 2 * BITWIDTH;

    state_t              state_reg, state_next;
    logic                start_q_reg;
    logic [1:0]          mode_reg, mode_next;
    logic [BITWIDTH-1:0] n_reg, n_next;
    logic [BITWIDTH-1:0] k_reg, k_next;
    logic [TW-1:0]       tick_reg, tick_next;
    logic [BITWIDTH-1:0] result_reg, result_next;
    logic                ovf_reg, ovf_next;

    logic                start_edge;
    logic [W2-1:0]       k_wide, term_wide, acc_wide, step_wide;
    logic                step_ovf;

    assign start_edge = start & ~start_q_reg;

    // Double-width step so any spill above the result width is visible.
    always_comb begin
        k_wide   = {{BITWIDTH{1'b0}}, k_reg};
        acc_wide = {{BITWIDTH{1'b0}}, result_reg};
        case (mode_reg)
            MODE_SQR: term_wide = k_wide * k_wide;
            MODE_ODD: term_wide = (k_wide << 1) - W2'(1);
            default:  term_wide = k_wide;
        endcase
        step_wide = (mode_reg == MODE_FACT) ? acc_wide * term_wide : acc_wide + term_wide;
        step_ovf  = (|term_wide[W2-1:BITWIDTH]) | (|step_wide[W2-1:BITWIDTH]);
    end

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        n_next      = n_reg;
        k_next      = k_reg;
        tick_next   = tick_reg;
        result_next = result_reg;
        ovf_next    = ovf_reg;
        if (clear) begin
            state_next  = ST_IDLE;
            result_next = '0;
            ovf_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        mode_next   = mode;
                        n_next      = n_terms;
                        result_next = (mode == MODE_FACT) ? BITWIDTH'(1) : '0;
                        ovf_next    = 1'b0;
                        k_next      = BITWIDTH'(1);
                        tick_next   = '0;
                        state_next  = (n_terms == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_reg == TW'(N_COMPUTE - 1)) begin
                        tick_next   = '0;
                        result_next = step_wide[BITWIDTH-1:0];
                        ovf_next    = ovf_reg | step_ovf;
                        k_next      = k_reg + BITWIDTH'(1);
                        if (k_reg == n_reg) begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            start_q_reg <= 1'b0;
            mode_reg    <= '0;
            n_reg       <= '0;
            k_reg       <= '0;
            tick_reg    <= '0;
            result_reg  <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            start_q_reg <= start;
            mode_reg    <= mode_next;
            n_reg       <= n_next;
            k_reg       <= k_next;
            tick_reg    <= tick_next;
            result_reg  <= result_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign result   = result_reg;
    assign overflow = ovf_reg;
    assign busy     = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);

    seg_scan #(
        .N_DIGITS  (N_DIGITS),
        .N_DISPLAY (N_DISPLAY),
        .WIDTH     (BITWIDTH)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .value (result_reg),
        .dp_n  (~ovf_reg),
        .seg   (seg),
        .an    (an)
    );

endmodule

// File: tb/tb_cal_seq.sv
// Bench for cal_seq: a cycle-count based series model checked every clock,
// plus directed runs with hand-computed results.
module tb_cal_seq;
    localparam int W    = 8;
    localparam int NC   = 2;
    localparam int ND   = 2;
    localparam int NDIG = 2;
    localparam longint MAXV = (longint'(1) << W) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            clear = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic [W-1:0]    n_terms = '0;
    logic [W-1:0]    result;
    logic            busy, done, overflow;
    logic [7:0]      seg;
    logic [NDIG-1:0] an;

    cal_seq #(.BITWIDTH(W), .N_COMPUTE(NC), .N_DISPLAY(ND), .N_DIGITS(NDIG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
        .n_terms(n_terms), .result(result), .busy(busy), .done(done),
        .overflow(overflow), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Series value after a given number of terms, straight from the definition.
    function automatic void fold(input int md, input int terms, output logic [W-1:0] r, output logic o);
        longint acc, t;
        acc = (md == 2) ? 1 : 0;
        o = 1'b0;
        for (int k = 1; k <= terms; k++) begin
            t = (md == 1) ? longint'(k * k) : (md == 3) ? longint'(2 * k - 1) : longint'(k);
            if (t > MAXV) o = 1'b1;
            acc = (md == 2) ? acc * t : acc + t;
            if (acc > MAXV) o = 1'b1;
            acc = acc % (MAXV + 1);
        end
        r = acc[W-1:0];
    endfunction

    // Model state: 0 idle, 1 run, 2 done; run progress derived from cycles since launch.
    int              cyc, m_state, m_e0, m_mode, m_n, sc, dg;
    logic            prev_start;
    logic [W-1:0]    e_res;
    logic            e_ovf, e_busy, e_done;
    logic [7:0]      e_seg;
    logic [NDIG-1:0] e_an;

    task automatic model_reset();
        cyc = 0; m_state = 0; m_e0 = 0; m_mode = 0; m_n = 0; sc = 0; dg = 0;
        prev_start = 1'b0;
        e_res = '0; e_ovf = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_an = ~NDIG'(1); e_seg = 8'hC0;
    endtask

    initial begin
        logic            edge_s, o;
        logic [W-1:0]    r;
        logic [7:0]      g;
        logic [NDIG-1:0] one;
        int              nib;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                cyc++;
                if (sc == ND - 1) begin
                    sc = 0;
                    dg = (dg + 1) % NDIG;
                end else begin
                    sc++;
                end
                one = NDIG'(1);
                e_an = ~(one << dg);
                nib = (int'(e_res) >> (4 * dg)) & 15;
                g = glyph[nib];
                e_seg = {(dg == 0) ? ~e_ovf : 1'b1, g[6:0]};
                edge_s = start && !prev_start;
                prev_start = start;
                if (clear) m_state = 0;
                else if (edge_s && m_state != 1) begin
                    m_mode = int'(mode); m_n = int'(n_terms); m_e0 = cyc;
                    m_state = (n_terms == '0) ? 2 : 1;
                end else if (m_state == 1 && cyc - m_e0 >= m_n * NC) m_state = 2;
                case (m_state)
                    1:       begin fold(m_mode, (cyc - m_e0) / NC, r, o); e_res = r; e_ovf = o; end
                    2:       begin fold(m_mode, m_n, r, o); e_res = r; e_ovf = o; end
                    default: begin e_res = '0; e_ovf = 1'b0; end
                endcase
                e_busy = (m_state == 1);
                e_done = (m_state == 2);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("result", 32'(result), 32'(e_res));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("overflow", 32'(overflow), 32'(e_ovf));
            check("an", 32'(an), 32'(e_an));
            check("seg", 32'(seg), 32'(e_seg));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_run(input logic [1:0] md, input logic [W-1:0] n,
                          input logic [W-1:0] exp_res, input logic exp_ovf);
        int busy_cnt = 0;
        int waited = 0;
        mode = md; n_terms = n; start = 1'b1;
        tick(1);
        check("identity_at_E0", 32'(result), (md == 2'b10) ? 32'd1 : 32'd0);
        check("ovf_at_E0", 32'(overflow), 32'd0);
        while (!done && waited < 600) begin
            if (busy) busy_cnt++;
            tick(1);
            waited++;
        end
        if (waited >= 600) check("done_timeout", 32'd0, 32'd1);
        $display("run mode=%0d n=%0d result=%h overflow=%0d busy_cycles=%0d",
                 md, n, result, overflow, busy_cnt);
        check("final_result", 32'(result), 32'(exp_res));
        check("final_ovf", 32'(overflow), 32'(exp_ovf));
        check("busy_cycles", busy_cnt, 32'(n) * NC);
        tick(4);
        check("no_retrigger_done", 32'(done), 32'd1);
        check("no_retrigger_busy", 32'(busy), 32'd0);
        start = 1'b0;
        tick(1);
    endtask

    task automatic wait_an(input logic [NDIG-1:0] target);
        int w = 0;
        while (an !== target && w < 10) begin tick(1); w++; end
        if (w >= 10) check("an_sync_timeout", 32'(an), 32'(target));
    endtask

    initial begin
        tick(3);
        check("rst_result", 32'(result), 32'd0);
        check("rst_an", 32'(an), 32'b10);
        check("rst_seg", 32'(seg), 32'hC0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: sum k, n=10
        do_run(2'b00, 8'd10, 8'h37, 1'b0);

        // 6: display scan of 0x37
        wait_an(2'b01);
        wait_an(2'b10);
        for (int i = 0; i < 2; i++) begin
            check("scan_an_d0", 32'(an), 32'b10);
            check("scan_seg_d0", 32'(seg), 32'hF8);
            tick(1);
        end
        for (int i = 0; i < 2; i++) begin
            check("scan_an_d1", 32'(an), 32'b01);
            check("scan_seg_d1", 32'(seg), 32'hB0);
            tick(1);
        end
        check("scan_wrap_an", 32'(an), 32'b10);

        // 2: sum k^2
        do_run(2'b01, 8'd7, 8'h8C, 1'b0);
        do_run(2'b01, 8'd9, 8'h1D, 1'b1);
        wait_an(2'b10);
        check("dp_digit0", 32'(seg), 32'h21);

        // 3: factorial; final run clears overflow at launch
        do_run(2'b10, 8'd5, 8'h78, 1'b0);
        do_run(2'b10, 8'd6, 8'hD0, 1'b1);
        do_run(2'b10, 8'd5, 8'h78, 1'b0);

        // 4: zero-term runs and odd series
        do_run(2'b10, 8'd0, 8'h01, 1'b0);
        do_run(2'b11, 8'd0, 8'h00, 1'b0);
        do_run(2'b11, 8'd4, 8'h10, 1'b0);

        // 5: async reset mid-run, clear beating a start edge, then a full run
        mode = 2'b00; n_terms = 8'd20; start = 1'b1;
        tick(11);
        rst_n = 1'b0;
        #1;
        check("arst_result", 32'(result), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        check("arst_an", 32'(an), 32'b10);
        check("arst_seg", 32'(seg), 32'hC0);
        start = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear = 1'b1; start = 1'b1;
        tick(1);
        check("clear_result", 32'(result), 32'd0);
        check("clear_busy", 32'(busy), 32'd0);
        check("clear_done", 32'(done), 32'd0);
        clear = 1'b0;
        tick(3);
        check("held_start_idle", 32'(busy), 32'd0);
        start = 1'b0;
        tick(1);
        do_run(2'b00, 8'd20, 8'hD2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
